// File: rtl/rvvi_reorder_receiver_if.sv
// Frame, acknowledge and in-order delivery signals between the RVVI host harness
// (master) and the reorder receiver (slave).
interface rvvi_reorder_receiver_if #(
    parameter int WIDTH = 792,
    parameter int FRAME_COUNT_WIDTH = 16
);
    logic                         RxValid;
    logic [WIDTH-1:0]             RxData;
    logic [FRAME_COUNT_WIDTH-1:0] RxFrameCount;
    logic                         AckValid;
    logic [FRAME_COUNT_WIDTH-1:0] AckFrameCount;
    logic                         OutValid;
    logic [WIDTH-1:0]             OutData;
    logic                         OutReady;
    logic [FRAME_COUNT_WIDTH-1:0] ExpectedCount;
    logic [15:0]                  DupCount;
    logic [15:0]                  DropCount;

    modport master (
        output RxValid, RxData, RxFrameCount, OutReady,
        input  AckValid, AckFrameCount, OutValid, OutData, ExpectedCount, DupCount, DropCount
    );

    modport slave (
        input  RxValid, RxData, RxFrameCount, OutReady,
        output AckValid, AckFrameCount, OutValid, OutData, ExpectedCount, DupCount, DropCount
    );
endinterface

// File: rtl/rvvi_reorder_receiver.sv
// Host-side RVVI reorder receiver: acknowledges incoming frames, holds them in a
// 2**Entries-slot reorder window and releases them downstream in frame-count order.
module rvvi_reorder_receiver #(
    parameter int Entries = 3,
    parameter int WIDTH = 792,
    parameter int FRAME_COUNT_WIDTH = 16
) (
    input logic clk,
    input logic reset,
    rvvi_reorder_receiver_if.slave bus
);
    localparam int Slots = 2 ** Entries;
    localparam logic [FRAME_COUNT_WIDTH-1:0] WindowSize = FRAME_COUNT_WIDTH'(Slots);

    logic [WIDTH-1:0]             payloadRam [Slots];
    logic [Slots-1:0]             slotValid;
    logic [Slots-1:0]             slotValidNext;
    logic [FRAME_COUNT_WIDTH-1:0] expectedCount;
    logic [FRAME_COUNT_WIDTH-1:0] offset;
    logic [Entries-1:0]           rxSlot;
    logic [Entries-1:0]           headSlot;
    logic                         inWindow;
    logic                         isStale;
    logic                         isNew;
    logic                         isDup;
    logic                         isAhead;
    logic                         doAck;
    logic                         deliver;
    logic                         ackValid;
    logic [FRAME_COUNT_WIDTH-1:0] ackFrameCount;
    logic [15:0]                  dupCount;
    logic [15:0]                  dropCount;

    // Offsets in the upper half of the count space are frames already delivered;
    // between the window and that half lie frames too far ahead to buffer.
    always_comb begin
        offset   = bus.RxFrameCount - expectedCount;
        rxSlot   = bus.RxFrameCount[Entries-1:0];
        headSlot = expectedCount[Entries-1:0];
        inWindow = offset < WindowSize;
        isStale  = offset[FRAME_COUNT_WIDTH-1];
        isNew    = bus.RxValid && inWindow && !slotValid[rxSlot];
        isDup    = bus.RxValid && ((inWindow && slotValid[rxSlot]) || isStale);
        isAhead  = bus.RxValid && !inWindow && !isStale;
        doAck    = isNew || isDup;
        deliver  = slotValid[headSlot] && bus.OutReady;
    end

    // The head slot is valid whenever it is delivered, so a same-cycle write
    // always targets a different slot and both updates can be applied.
    always_comb begin
        slotValidNext = slotValid;
        if (deliver) begin
            slotValidNext[headSlot] = 1'b0;
        end
        if (isNew) begin
            slotValidNext[rxSlot] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            slotValid     <= '0;
            expectedCount <= '0;
            ackValid      <= 1'b0;
            ackFrameCount <= '0;
            dupCount      <= '0;
            dropCount     <= '0;
        end else begin
            slotValid <= slotValidNext;
            if (deliver) begin
                expectedCount <= expectedCount + FRAME_COUNT_WIDTH'(1);
            end
            ackValid <= doAck;
            if (doAck) begin
                ackFrameCount <= bus.RxFrameCount;
            end
            if (isDup && dupCount != 16'hFFFF) begin
                dupCount <= dupCount + 16'd1;
            end
            if (isAhead && dropCount != 16'hFFFF) begin
                dropCount <= dropCount + 16'd1;
            end
        end
    end

    // Payload storage carries no reset; slotValid alone says what is meaningful.
    always_ff @(posedge clk) begin
        if (isNew) begin
            payloadRam[rxSlot] <= bus.RxData;
        end
    end

    assign bus.OutValid      = slotValid[headSlot];
    assign bus.OutData       = payloadRam[headSlot];
    assign bus.ExpectedCount = expectedCount;
    assign bus.AckValid      = ackValid;
    assign bus.AckFrameCount = ackFrameCount;
    assign bus.DupCount      = dupCount;
    assign bus.DropCount     = dropCount;
endmodule

// File: tb/tb_rvvi_reorder_receiver.sv
// Self-checking bench for rvvi_reorder_receiver: a frame-count keyed model is
// compared against the DUT every cycle, plus literal checks per scenario.
module tb_rvvi_reorder_receiver;
    localparam int ENT = 3;
    localparam int W   = 792;
    localparam int FCW = 16;

    logic clk;
    logic reset;

    rvvi_reorder_receiver_if #(.WIDTH(W), .FRAME_COUNT_WIDTH(FCW)) bus();

    rvvi_reorder_receiver #(.Entries(ENT), .WIDTH(W), .FRAME_COUNT_WIDTH(FCW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int compared = 0;
    int mismatched = 0;
    bit modelLive = 0;

    logic [W-1:0] mBuf [int];
    int mExp;
    bit mAckValid;
    int mAckCount;
    int mDup;
    int mDrop;
    bit mDeliver;
    int mDiff;
    int mRx;

    int deliveredQ[$];
    int ackQ[$];

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic logic [W-1:0] payloadOf(input logic [FCW-1:0] fc);
        return {8'hC3, {49{fc ^ 16'h5A5A}}};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, wanted %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkSeq(input string name, input int act[$], input int exp[$]);
        checkOutput({name, "_len"}, 64'(act.size()), 64'(exp.size()));
        for (int i = 0; i < act.size() && i < exp.size(); i++) begin
            checkOutput(name, 64'(act[i]), 64'(exp[i]));
        end
    endtask

    task automatic applyStimulus(input bit valid, input int fc, input bit ready);
        bus.RxValid      = valid;
        bus.RxFrameCount = FCW'(fc);
        bus.RxData       = payloadOf(FCW'(fc));
        bus.OutReady     = ready;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit ready);
        for (int i = 0; i < n; i++) begin
            applyStimulus(0, 0, ready);
        end
    endtask

    task automatic doReset();
        reset = 0;
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        reset = 1;
        deliveredQ.delete();
        ackQ.delete();
    endtask

    // Model: frames keyed by full count; classification by modular distance
    // from the next count to deliver, delivery judged on pre-edge contents.
    initial begin
        forever begin
            @(posedge clk);
            if (!reset) begin
                mBuf.delete();
                mExp = 0;
                mAckValid = 0;
                mAckCount = 0;
                mDup = 0;
                mDrop = 0;
                modelLive = 1;
            end else if (modelLive) begin
                mDeliver = mBuf.exists(mExp) && (bus.OutReady === 1'b1);
                mAckValid = 0;
                if (bus.RxValid === 1'b1) begin
                    mRx = int'(bus.RxFrameCount);
                    mDiff = (mRx - mExp + 65536) % 65536;
                    if (mDiff < 2 ** ENT) begin
                        if (mBuf.exists(mRx)) begin
                            mDup = (mDup < 65535) ? mDup + 1 : mDup;
                        end else begin
                            mBuf[mRx] = bus.RxData;
                        end
                        mAckValid = 1;
                        mAckCount = mRx;
                    end else if (mDiff >= 32768) begin
                        mDup = (mDup < 65535) ? mDup + 1 : mDup;
                        mAckValid = 1;
                        mAckCount = mRx;
                    end else begin
                        mDrop = (mDrop < 65535) ? mDrop + 1 : mDrop;
                    end
                end
                if (mDeliver) begin
                    mBuf.delete(mExp);
                    mExp = (mExp + 1) % 65536;
                end
            end
        end
    end

    // Compare process on the falling edge, also logging delivered frames and acks.
    initial begin
        forever begin
            @(negedge clk);
            if (modelLive && reset === 1'b1) begin
                checkOutput("OutValid", 64'(bus.OutValid), 64'(mBuf.exists(mExp)));
                checkOutput("ExpectedCount", 64'(bus.ExpectedCount), 64'(mExp));
                checkOutput("AckValid", 64'(bus.AckValid), 64'(mAckValid));
                if (mAckValid) begin
                    checkOutput("AckFrameCount", 64'(bus.AckFrameCount), 64'(mAckCount));
                end
                checkOutput("DupCount", 64'(bus.DupCount), 64'(mDup));
                checkOutput("DropCount", 64'(bus.DropCount), 64'(mDrop));
                if (mBuf.exists(mExp)) begin
                    compared++;
                    if (bus.OutData !== mBuf[mExp]) begin
                        mismatched++;
                        $display("[TB] FAIL OutData: got low %0h, wanted low %0h at %0t",
                                 bus.OutData[63:0], mBuf[mExp][63:0], $time);
                    end
                end
                if (bus.OutValid === 1'b1 && bus.OutReady === 1'b1) begin
                    deliveredQ.push_back(int'(bus.OutData[15:0] ^ 16'h5A5A));
                end
                if (bus.AckValid === 1'b1) begin
                    ackQ.push_back(int'(bus.AckFrameCount));
                end
            end
        end
    end

    initial begin
        int e[$];
        int a[$];
        bus.RxValid = 0;
        bus.RxData = '0;
        bus.RxFrameCount = '0;
        bus.OutReady = 0;
        reset = 0;

        $display("[TB] in-order stream");
        doReset();
        checkOutput("reset_OutValid", 64'(bus.OutValid), 64'd0);
        checkOutput("reset_ExpectedCount", 64'(bus.ExpectedCount), 64'd0);
        for (int i = 0; i < 10; i++) applyStimulus(1, i, 1);
        idle(3, 1);
        checkOutput("t1_ExpectedCount", 64'(bus.ExpectedCount), 64'd10);
        checkOutput("t1_DupCount", 64'(bus.DupCount), 64'd0);
        checkOutput("t1_DropCount", 64'(bus.DropCount), 64'd0);
        e.delete();
        for (int i = 0; i < 10; i++) e.push_back(i);
        checkSeq("t1_delivered", deliveredQ, e);
        checkSeq("t1_acks", ackQ, e);

        $display("[TB] reorder");
        doReset();
        applyStimulus(1, 2, 1);
        applyStimulus(1, 1, 1);
        applyStimulus(1, 3, 1);
        idle(2, 1);
        checkOutput("t2_hold_OutValid", 64'(bus.OutValid), 64'd0);
        applyStimulus(1, 0, 1);
        idle(6, 1);
        e = '{0, 1, 2, 3};
        checkSeq("t2_delivered", deliveredQ, e);
        a = '{2, 1, 3, 0};
        checkSeq("t2_acks", ackQ, a);
        checkOutput("t2_ExpectedCount", 64'(bus.ExpectedCount), 64'd4);

        $display("[TB] duplicate and replay");
        doReset();
        applyStimulus(1, 0, 1);
        applyStimulus(1, 1, 1);
        idle(2, 1);
        applyStimulus(1, 1, 1);
        applyStimulus(1, 5, 1);
        applyStimulus(1, 5, 1);
        idle(1, 1);
        checkOutput("t3_DupCount", 64'(bus.DupCount), 64'd2);
        checkOutput("t3_OutValid", 64'(bus.OutValid), 64'd0);
        for (int i = 2; i < 5; i++) applyStimulus(1, i, 1);
        idle(6, 1);
        e = '{0, 1, 2, 3, 4, 5};
        checkSeq("t3_delivered", deliveredQ, e);
        a = '{0, 1, 1, 5, 5, 2, 3, 4};
        checkSeq("t3_acks", ackQ, a);

        $display("[TB] out of window");
        doReset();
        applyStimulus(1, 8, 1);
        idle(2, 1);
        checkOutput("t4_DropCount", 64'(bus.DropCount), 64'd1);
        checkOutput("t4_OutValid", 64'(bus.OutValid), 64'd0);
        checkOutput("t4_no_ack", 64'(ackQ.size()), 64'd0);
        for (int i = 0; i < 9; i++) applyStimulus(1, i, 1);
        idle(3, 1);
        e.delete();
        for (int i = 0; i < 9; i++) e.push_back(i);
        checkSeq("t4_delivered", deliveredQ, e);
        checkOutput("t4_ExpectedCount", 64'(bus.ExpectedCount), 64'd9);

        $display("[TB] backpressure and full window");
        doReset();
        for (int i = 0; i < 8; i++) applyStimulus(1, i, 0);
        applyStimulus(1, 3, 0);
        applyStimulus(1, 8, 0);
        idle(2, 0);
        checkOutput("t5_DupCount", 64'(bus.DupCount), 64'd1);
        checkOutput("t5_DropCount", 64'(bus.DropCount), 64'd1);
        checkOutput("t5_OutValid", 64'(bus.OutValid), 64'd1);
        checkOutput("t5_held", 64'(deliveredQ.size()), 64'd0);
        a = '{0, 1, 2, 3, 4, 5, 6, 7, 3};
        checkSeq("t5_acks", ackQ, a);
        idle(10, 1);
        checkOutput("t5_ExpectedCount", 64'(bus.ExpectedCount), 64'd8);
        applyStimulus(1, 8, 1);
        idle(3, 1);
        e.delete();
        for (int i = 0; i < 9; i++) e.push_back(i);
        checkSeq("t5_delivered", deliveredQ, e);

        $display("[TB] frame-count wrap and mid-run reset");
        doReset();
        for (int i = 0; i < 16'hFFFE; i++) applyStimulus(1, i, 1);
        idle(3, 1);
        checkOutput("t6_preload", 64'(bus.ExpectedCount), 64'hFFFE);
        deliveredQ.delete();
        ackQ.delete();
        applyStimulus(1, 16'hFFFF, 1);
        applyStimulus(1, 16'hFFFE, 1);
        applyStimulus(1, 16'h0000, 1);
        idle(5, 1);
        e = '{16'hFFFE, 16'hFFFF, 0};
        checkSeq("t6_delivered", deliveredQ, e);
        a = '{16'hFFFF, 16'hFFFE, 0};
        checkSeq("t6_acks", ackQ, a);
        checkOutput("t6_ExpectedCount", 64'(bus.ExpectedCount), 64'd1);
        applyStimulus(1, 1, 0);
        applyStimulus(1, 2, 0);
        applyStimulus(1, 3, 0);
        applyStimulus(1, 2, 0);
        applyStimulus(1, 1000, 0);
        checkOutput("t6_pre_OutValid", 64'(bus.OutValid), 64'd1);
        checkOutput("t6_pre_DupCount", 64'(bus.DupCount), 64'd1);
        checkOutput("t6_pre_DropCount", 64'(bus.DropCount), 64'd1);
        reset = 0;
        applyStimulus(1, 4, 0);
        checkOutput("t6_rst_OutValid", 64'(bus.OutValid), 64'd0);
        checkOutput("t6_rst_ExpectedCount", 64'(bus.ExpectedCount), 64'd0);
        checkOutput("t6_rst_DupCount", 64'(bus.DupCount), 64'd0);
        checkOutput("t6_rst_DropCount", 64'(bus.DropCount), 64'd0);
        checkOutput("t6_rst_AckValid", 64'(bus.AckValid), 64'd0);
        reset = 1;
        idle(2, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
